// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad column scanner with whole-scan debounce and key strobes
module keypad_scanner #(
    parameter int SCAN_CYCLES    = 8,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_in,
    output logic [3:0] col_drive,
    output logic [3:0] digit,
    output logic       valid,
    output logic       cmd_valid,
    output logic       key_held
);
    localparam int DW = $clog2(SCAN_CYCLES);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} state_t;

    logic [3:0]    row_s1, row_s2;
    logic [DW-1:0] dwell;
    logic [1:0]    col;
    logic [11:0]   keys_lo;
    logic [15:0]   scan_now;
    logic          sample, scan_done;
    logic [4:0]    nkeys;
    logic [3:0]    hit, hit_code;
    logic          one, none;
    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    cand, cand_n, digit_n;
    logic          valid_n, cmd_n;
    logic          accept;
    logic [3:0]    accept_code;

    function automatic logic [3:0] keycode(input logic [3:0] rc);
        case (rc)
            4'd0:  keycode = 4'h1;
            4'd1:  keycode = 4'h2;
            4'd2:  keycode = 4'h3;
            4'd3:  keycode = 4'hA;
            4'd4:  keycode = 4'h4;
            4'd5:  keycode = 4'h5;
            4'd6:  keycode = 4'h6;
            4'd7:  keycode = 4'hB;
            4'd8:  keycode = 4'h7;
            4'd9:  keycode = 4'h8;
            4'd10: keycode = 4'h9;
            4'd11: keycode = 4'hC;
            4'd12: keycode = 4'hE;
            4'd13: keycode = 4'h0;
            4'd14: keycode = 4'hF;
            default: keycode = 4'hD;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_s1 <= 4'hF;
            row_s2 <= 4'hF;
        end else begin
            row_s1 <= row_in;
            row_s2 <= row_s1;
        end
    end

    assign sample    = (dwell == DW'(SCAN_CYCLES - 1));
    assign scan_done = sample && (col == 2'd3);
    assign col_drive = ~(4'b0001 << col);

    // keys_lo holds columns 0..2 (bit = col*4+row); column 3 is taken live at the final sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell   <= '0;
            col     <= 2'd0;
            keys_lo <= '0;
        end else if (sample) begin
            dwell <= '0;
            col   <= col + 2'd1;
            case (col)
                2'd0:    keys_lo[3:0]  <= ~row_s2;
                2'd1:    keys_lo[7:4]  <= ~row_s2;
                2'd2:    keys_lo[11:8] <= ~row_s2;
                default: ;
            endcase
        end else begin
            dwell <= dwell + DW'(1);
        end
    end

    assign scan_now = {~row_s2, keys_lo};

    always_comb begin
        nkeys = '0;
        hit   = '0;
        for (int i = 0; i < 16; i++) begin
            if (scan_now[i]) begin
                nkeys = nkeys + 5'd1;
                hit   = i[3:0];
            end
        end
    end

    assign one      = (nkeys == 5'd1);
    assign none     = (nkeys == 5'd0);
    assign hit_code = keycode({hit[1:0], hit[3:2]});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            cand      <= '0;
            digit     <= '0;
            valid     <= 1'b0;
            cmd_valid <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            cand      <= cand_n;
            digit     <= digit_n;
            valid     <= valid_n;
            cmd_valid <= cmd_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        cand_n      = cand;
        accept      = 1'b0;
        accept_code = cand;
        if (scan_done) begin
            case (state)
                IDLE: if (one) begin
                    cand_n = hit_code;
                    cnt_n  = CW'(1);
                    if (DEBOUNCE_SCANS == 1) begin
                        accept      = 1'b1;
                        accept_code = hit_code;
                        state_n     = HELD;
                    end else begin
                        state_n = DEBOUNCE;
                    end
                end
                DEBOUNCE: if (one && hit_code == cand) begin
                    cnt_n = cnt + CW'(1);
                    if (cnt + CW'(1) == CW'(DEBOUNCE_SCANS)) begin
                        accept  = 1'b1;
                        state_n = HELD;
                    end
                end else if (one) begin
                    cand_n = hit_code;
                    cnt_n  = CW'(1);
                end else begin
                    state_n = IDLE;
                end
                HELD: if (none) begin
                    cnt_n   = CW'(1);
                    state_n = (DEBOUNCE_SCANS == 1) ? IDLE : RELEASE;
                end
                default: if (none) begin
                    cnt_n = cnt + CW'(1);
                    if (cnt + CW'(1) == CW'(DEBOUNCE_SCANS))
                        state_n = IDLE;
                end else begin
                    state_n = HELD;
                end
            endcase
        end
        digit_n = accept ? accept_code : digit;
        valid_n = accept && (accept_code <= 4'd9);
        cmd_n   = accept && (accept_code > 4'd9);
    end

    assign key_held = (state == HELD) || (state == RELEASE);
endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 matrix keypad, debounces it, and produces the serial key-entry stream that the digital lock FSM consumes. Numeric keys appear as `digit` with a 1-cycle `valid` strobe; non-numeric keys use a separate strobe. The block sits between the keypad pins and the lock, one clock domain, no software involvement.

## Interface
- `SCAN_CYCLES`, 8: clock cycles each column is driven (dwell). Minimum 4.
- `DEBOUNCE_SCANS`, 4: consecutive identical full scans required to accept a press or a release. Minimum 1.

- `clk`  in  1  system clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `row_in`  in  4  keypad rows, active-low (pulled up), asynchronous to `clk`
- `col_drive`  out  4  column drive, active-low, one-hot-zero
- `digit`  out  4  key code of the last accepted key (0..9 numeric, 0xA..0xF others)
- `valid`  out  1  1-cycle strobe, numeric key accepted
- `cmd_valid`  out  1  1-cycle strobe, non-numeric key accepted
- `key_held`  out  1  high while an accepted key is considered pressed

## Operation
- Keymap, [row][col]: r0 = 1 2 3 A; r1 = 4 5 6 B; r2 = 7 8 9 C; r3 = * 0 # D. Codes: digits literal, A..D = 0xA..0xD, * = 0xE, # = 0xF.
- `row_in` passes through a 2-flop synchronizer; sync flops reset to 4'b1111.
- Column scan:
  - `col` 0..3 advances every `SCAN_CYCLES` and wraps 3 -> 0.
  - `col_drive` = ~(1 << `col`).
  - Rows are sampled on the last dwell cycle of each column.
  - Key (r,c) is pressed if synced `row_in[r]`==0 while column c is driven.
- Scan result is classified at the column-3 sample:
  - NONE: 0 keys pressed.
  - ONE(k): exactly 1 key pressed.
  - MULTI: 2 or more keys pressed.
- Debounce FSM, updated once per scan result. `cnt` is $clog2(DEBOUNCE_SCANS+1) bits.
  - IDLE:
    - ONE(k): set `cand`=k, `cnt`=1, go to DEBOUNCE. If `DEBOUNCE_SCANS`==1, accept immediately and go to HELD.
    - NONE or MULTI: stay in IDLE.
  - DEBOUNCE:
    - ONE(`cand`): `cnt`++. When `cnt` reaches `DEBOUNCE_SCANS`, accept and go to HELD.
    - ONE(other): set `cand`=other, `cnt`=1.
    - NONE or MULTI: go to IDLE.
  - HELD:
    - NONE: set `cnt`=1, go to RELEASE. If `DEBOUNCE_SCANS`==1, go to IDLE.
    - ONE(any) or MULTI: stay in HELD. No rollover and no auto-repeat.
  - RELEASE:
    - NONE: `cnt`++. When `cnt` reaches `DEBOUNCE_SCANS`, go to IDLE.
    - Anything else: go to HELD, with no new strobe.
- Accept means:
  - `digit` <= `cand`.
  - Pulse `valid` if `cand` <= 9, otherwise pulse `cmd_valid`.
  - Exactly one strobe per physical press.
- `digit` holds its value until the next accept.
- `key_held` = 1 in HELD and RELEASE.
- Strobes are never asserted together, and never on consecutive cycles.

## Timing
- Reset values while `rst_n` is low and immediately on assertion:
  - `col_drive`=4'b1110, `col`=0, dwell counter 0.
  - FSM in IDLE.
  - `digit`=0, `valid`=0, `cmd_valid`=0, `key_held`=0.
- Scan period is 4*`SCAN_CYCLES` cycles. The first column-0 sample occurs `SCAN_CYCLES` cycles after reset release.
- Strobe latency: asserted on the cycle after the column-3 sample of the accepting scan. Registered outputs; no combinational path from `row_in`.
- `key_held` and `digit` update on the same cycle as the strobe. `key_held` falls on the cycle after the column-3 sample of the final release scan.
- Column change to sample is `SCAN_CYCLES`-1 cycles. This covers 2 sync stages plus pin settle.
- A press that spans only part of a scan yields a partial scan that is not ONE(k). Acceptance counts whole scans only.
- Reset mid-operation aborts the scan and FSM with no strobe. A key still held after reset is re-debounced and emits again.

## Test plan
All cases use defaults (8, 4); scan = 32 cycles.

1. **Reset and column sweep.** Release `rst_n`, rows idle 4'b1111.
   - `col_drive` cycles 1110 -> 1101 -> 1011 -> 0111, 8 cycles each, and wraps.
   - All outputs stay 0 for 10 scans.
2. **Single numeric press.** Press '5' (row1 low while col1 driven) for 10 scans, then release.
   - Exactly one `valid` with `digit`=5, 1 cycle after the col-3 sample of the 4th full pressed scan.
   - `key_held` falls after the 4th full released scan.
3. **Bounce rejection.** '7' pressed 2 scans, released 1 scan, pressed 3 scans, then released.
   - No `valid` or `cmd_valid`.
   - `key_held` stays 0 and `digit` stays 0.
4. **Command key.** Press '#' for 6 scans.
   - One `cmd_valid`, `digit`=0xF, `valid` stays 0.
   - Then press '0' for 6 scans: one `valid` with `digit`=0.
5. **Multi-key and rollover.**
   - '1' and '2' pressed together for 8 scans: no strobe.
   - '1' alone until accepted (`digit`=1), then '2' added for 6 scans, then both released: no second strobe.
6. **Reset mid-hold.** Assert `rst_n` low while in HELD with '9' still pressed.
   - Outputs clear immediately and `col_drive`=1110.
   - After release of reset with '9' still held, `valid` with `digit`=9 fires again after 4 full scans.
